uart_ctrl: RTL and testbench

UART_CTRL -- requirements
Module: uart_ctrl

---
 rtl/uart_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_uart_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ctrl.sv
// UART controller: baud tick generator, TX/RX serial FSMs and TX/RX FIFOs.
// Optional macro UART_FIFO_EN: FIFO_DEPTH-entry FIFOs; otherwise one holding register per direction.
module uart_ctrl #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int OVS        = 16
) (
  input  logic              uart_clk,
  input  logic              sys_rstn,
  input  logic              cfg_en,
  input  logic [15:0]       cfg_div,
  input  logic              cfg_prty_en,
  input  logic              cfg_prty_odd,
  input  logic              cfg_stop2,
  input  logic              cfg_txie,
  input  logic              cfg_rxie,
  input  logic              err_clr,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_perr,
  output logic              rx_ferr,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_ovf,
  output logic              tx_idle,
  output logic              uart_tx,
  input  logic              uart_rx,
  output logic              uart_int
);

`ifdef UART_FIFO_EN
  localparam int DEPTH = FIFO_DEPTH;
`else
  // Single holding register; FIFO_DEPTH has no effect in this build.
  localparam int DEPTH = 1 + 0 * FIFO_DEPTH;
`endif
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(OVS);
  localparam int BW = $clog2(DATA_W);
  localparam int RW = DATA_W + 2;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  function automatic logic par_bit(input logic [DATA_W-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  function automatic logic [AW-1:0] ptr_nxt(input logic [AW-1:0] p);
    if (DEPTH == 1) return '0;
    else            return p + AW'(1);
  endfunction

  logic              r_run;
  logic [15:0]       r_tick_cnt;
  logic [15:0]       r_tick_div;
  logic              w_tick;

  logic [DATA_W-1:0] r_txf_mem [DEPTH];
  logic [AW-1:0]     r_txf_wr, r_txf_rd;
  logic [CW-1:0]     r_txf_cnt;
  logic              w_txf_full, w_txf_empty, w_tx_push, w_tx_pop;
  logic [DATA_W-1:0] w_txf_head;

  logic [RW-1:0]     r_rxf_mem [DEPTH];
  logic [AW-1:0]     r_rxf_wr, r_rxf_rd;
  logic [CW-1:0]     r_rxf_cnt;
  logic              w_rxf_full, w_rxf_empty, w_rxf_push, w_rxf_pop, w_ovf_set;
  logic [RW-1:0]     w_rxf_head;

  tx_state_t         r_tx_st;
  logic [OW-1:0]     r_tx_ovs;
  logic [BW-1:0]     r_tx_bit;
  logic [DATA_W-1:0] r_tx_sh;
  logic              r_tx_par, r_tx_pen, r_tx_stop2, r_uart_tx;
  logic              w_tx_bit_end;

  rx_state_t         r_rx_st;
  logic              r_rx_s1, r_rx_s2, r_rx_s3;
  logic [OW-1:0]     r_rx_ovs;
  logic [BW-1:0]     r_rx_bit;
  logic [DATA_W-1:0] r_rx_sh;
  logic              r_rx_pen, r_rx_podd, r_rx_pbit, r_rx_push, r_rx_ovf;
  logic [RW-1:0]     r_rx_word;
  logic              w_rx_fall, w_rx_samp, w_rx_perr;

  // Holds tx_ready and uart_int low while reset is asserted.
  always_ff @(posedge uart_clk or negedge sys_rstn) begin
    if (!sys_rstn) r_run <= 1'b0;
    else           r_run <= 1'b1;
  end

  // Baud tick: the divider is re-latched only at a tick so a period is never cut short.
  assign w_tick = cfg_en & (r_tick_cnt == r_tick_div);

  always_ff @(posedge uart_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_tick_cnt <= '0;
      r_tick_div <= '0;
    end else if (!cfg_en) begin
      r_tick_cnt <= '0;
      r_tick_div <= cfg_div;
    end else if (r_tick_cnt == r_tick_div) begin
      r_tick_cnt <= '0;
      r_tick_div <= cfg_div;
    end else begin
      r_tick_cnt <= r_tick_cnt + 16'd1;
    end
  end

  assign w_txf_full  = (r_txf_cnt == CW'(DEPTH));
  assign w_txf_empty = (r_txf_cnt == '0);
  assign w_txf_head  = r_txf_mem[r_txf_rd];
  assign tx_ready    = cfg_en & r_run & ~w_txf_full;
  assign w_tx_push   = tx_valid & tx_ready;
  assign w_tx_pop    = cfg_en & (r_tx_st == TX_IDLE) & ~w_txf_empty;

  always_ff @(posedge uart_clk or negedge sys_rstn) begin
    if (!sys_rstn || !cfg_en) begin
      r_txf_wr  <= '0;
      r_txf_rd  <= '0;
      r_txf_cnt <= '0;
    end else begin
      if (w_tx_push) r_txf_wr <= ptr_nxt(r_txf_wr);
      if (w_tx_pop)  r_txf_rd <= ptr_nxt(r_txf_rd);
      r_txf_cnt <= r_txf_cnt + CW'(w_tx_push) - CW'(w_tx_pop);
    end
  end

  always_ff @(posedge uart_clk) begin
    if (w_tx_push) r_txf_mem[r_txf_wr] <= tx_data;
  end

  // A push onto a full RX FIFO survives only if the head is popped in the same cycle.
  assign w_rxf_full  = (r_rxf_cnt == CW'(DEPTH));
  assign w_rxf_empty = (r_rxf_cnt == '0);
  assign w_rxf_head  = r_rxf_mem[r_rxf_rd];
  assign w_rxf_pop   = rx_valid & rx_ready;
  assign w_rxf_push  = r_rx_push & (~w_rxf_full | w_rxf_pop);
  assign w_ovf_set   = r_rx_push & w_rxf_full & ~w_rxf_pop;

  always_ff @(posedge uart_clk or negedge sys_rstn) begin
    if (!sys_rstn || !cfg_en) begin
      r_rxf_wr  <= '0;
      r_rxf_rd  <= '0;
      r_rxf_cnt <= '0;
      r_rx_ovf  <= 1'b0;
    end else begin
      if (w_rxf_push) r_rxf_wr <= ptr_nxt(r_rxf_wr);
      if (w_rxf_pop)  r_rxf_rd <= ptr_nxt(r_rxf_rd);
      r_rxf_cnt <= r_rxf_cnt + CW'(w_rxf_push) - CW'(w_rxf_pop);
      if (w_ovf_set)    r_rx_ovf <= 1'b1;
      else if (err_clr) r_rx_ovf <= 1'b0;
    end
  end

  always_ff @(posedge uart_clk) begin
    if (w_rxf_push) r_rxf_mem[r_rxf_wr] <= r_rx_word;
  end

  // TX serialiser: r_tx_sh shifts right so bit 1 is always the next data bit.
  assign w_tx_bit_end = w_tick & (r_tx_ovs == OW'(OVS - 1));

  always_ff @(posedge uart_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_tx_st    <= TX_IDLE;
      r_tx_ovs   <= '0;
      r_tx_bit   <= '0;
      r_tx_sh    <= '0;
      r_tx_par   <= 1'b0;
      r_tx_pen   <= 1'b0;
      r_tx_stop2 <= 1'b0;
      r_uart_tx  <= 1'b1;
    end else if (!cfg_en) begin
      r_tx_st   <= TX_IDLE;
      r_tx_ovs  <= '0;
      r_tx_bit  <= '0;
      r_uart_tx <= 1'b1;
    end else begin
      if (r_tx_st == TX_IDLE)  r_tx_ovs <= '0;
      else if (w_tx_bit_end)   r_tx_ovs <= '0;
      else if (w_tick)         r_tx_ovs <= r_tx_ovs + OW'(1);
      case (r_tx_st)
        TX_IDLE: begin
          r_uart_tx <= 1'b1;
          if (!w_txf_empty) begin
            r_tx_sh    <= w_txf_head;
            r_tx_par   <= par_bit(w_txf_head, cfg_prty_odd);
            r_tx_pen   <= cfg_prty_en;
            r_tx_stop2 <= cfg_stop2;
            r_uart_tx  <= 1'b0;
            r_tx_st    <= TX_START;
          end
        end
        TX_START: if (w_tx_bit_end) begin
          r_uart_tx <= r_tx_sh[0];
          r_tx_bit  <= '0;
          r_tx_st   <= TX_DATA;
        end
        TX_DATA: if (w_tx_bit_end) begin
          r_tx_sh <= r_tx_sh >> 1;
          if (r_tx_bit == BW'(DATA_W - 1)) begin
            r_tx_bit <= '0;
            if (r_tx_pen) begin
              r_uart_tx <= r_tx_par;
              r_tx_st   <= TX_PARITY;
            end else begin
              r_uart_tx <= 1'b1;
              r_tx_st   <= TX_STOP;
            end
          end else begin
            r_tx_bit  <= r_tx_bit + BW'(1);
            r_uart_tx <= r_tx_sh[1];
          end
        end
        TX_PARITY: if (w_tx_bit_end) begin
          r_uart_tx <= 1'b1;
          r_tx_st   <= TX_STOP;
        end
        TX_STOP: if (w_tx_bit_end) begin
          if (r_tx_stop2 && (r_tx_bit == '0)) begin
            r_tx_bit <= BW'(1);
          end else begin
            r_tx_bit <= '0;
            r_tx_st  <= TX_IDLE;
          end
        end
        default: r_tx_st <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge uart_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= uart_rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end

  // Start bit is checked half a bit after the edge; every later sample lands mid-bit.
  assign w_rx_fall = r_rx_s3 & ~r_rx_s2;
  assign w_rx_samp = w_tick & ((r_rx_st == RX_START) ? (r_rx_ovs == OW'(OVS / 2 - 1))
                                                     : (r_rx_ovs == OW'(OVS - 1)));
  assign w_rx_perr = r_rx_pen & (par_bit(r_rx_sh, r_rx_podd) != r_rx_pbit);

  always_ff @(posedge uart_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_rx_st   <= RX_IDLE;
      r_rx_ovs  <= '0;
      r_rx_bit  <= '0;
      r_rx_sh   <= '0;
      r_rx_pen  <= 1'b0;
      r_rx_podd <= 1'b0;
      r_rx_pbit <= 1'b0;
      r_rx_push <= 1'b0;
      r_rx_word <= '0;
    end else if (!cfg_en) begin
      r_rx_st   <= RX_IDLE;
      r_rx_ovs  <= '0;
      r_rx_bit  <= '0;
      r_rx_push <= 1'b0;
    end else begin
      r_rx_push <= 1'b0;
      if (r_rx_st == RX_IDLE) r_rx_ovs <= '0;
      else if (w_rx_samp)     r_rx_ovs <= '0;
      else if (w_tick)        r_rx_ovs <= r_rx_ovs + OW'(1);
      case (r_rx_st)
        RX_IDLE: if (w_rx_fall) begin
          r_rx_pen  <= cfg_prty_en;
          r_rx_podd <= cfg_prty_odd;
          r_rx_st   <= RX_START;
        end
        RX_START: if (w_rx_samp) begin
          r_rx_bit <= '0;
          r_rx_st  <= r_rx_s2 ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (w_rx_samp) begin
          r_rx_sh <= {r_rx_s2, r_rx_sh[DATA_W-1:1]};
          if (r_rx_bit == BW'(DATA_W - 1)) begin
            r_rx_bit <= '0;
            r_rx_st  <= r_rx_pen ? RX_PARITY : RX_STOP;
          end else begin
            r_rx_bit <= r_rx_bit + BW'(1);
          end
        end
        RX_PARITY: if (w_rx_samp) begin
          r_rx_pbit <= r_rx_s2;
          r_rx_st   <= RX_STOP;
        end
        RX_STOP: if (w_rx_samp) begin
          r_rx_word <= {w_rx_perr, ~r_rx_s2, r_rx_sh};
          r_rx_push <= 1'b1;
          r_rx_st   <= RX_IDLE;
        end
        default: r_rx_st <= RX_IDLE;
      endcase
    end
  end

  assign uart_tx  = r_uart_tx;
  assign tx_idle  = (r_tx_st == TX_IDLE) & w_txf_empty;
  assign rx_valid = ~w_rxf_empty;
  assign rx_data  = rx_valid ? w_rxf_head[DATA_W-1:0] : '0;
  assign rx_ferr  = rx_valid & w_rxf_head[DATA_W];
  assign rx_perr  = rx_valid & w_rxf_head[DATA_W+1];
  assign rx_ovf   = r_rx_ovf;
  assign uart_int = r_run & ((cfg_txie & tx_idle) | (cfg_rxie & rx_valid) | r_rx_ovf);

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl: TX framing, parity, loopback, RX errors, overflow, reset.
module tb_uart_ctrl;

`ifdef UART_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       uart_clk = 1'b0;
  logic       sys_rstn, cfg_en, cfg_prty_en, cfg_prty_odd, cfg_stop2, cfg_txie, cfg_rxie;
  logic       err_clr, tx_valid, tx_ready, rx_perr, rx_ferr, rx_valid, rx_ready, rx_ovf;
  logic       tx_idle, uart_tx, uart_int, loop, r_rx_drv;
  logic [15:0] cfg_div;
  logic [7:0] tx_data, rx_data;
  wire        w_uart_rx = loop ? uart_tx : r_rx_drv;

  int n_chk = 0;
  int n_fail = 0;

  always #5 uart_clk = ~uart_clk;

  uart_ctrl #(.DATA_W(8), .FIFO_DEPTH(4), .OVS(16)) dut (
    .uart_clk(uart_clk), .sys_rstn(sys_rstn), .cfg_en(cfg_en), .cfg_div(cfg_div),
    .cfg_prty_en(cfg_prty_en), .cfg_prty_odd(cfg_prty_odd), .cfg_stop2(cfg_stop2),
    .cfg_txie(cfg_txie), .cfg_rxie(cfg_rxie), .err_clr(err_clr),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_ovf(rx_ovf), .tx_idle(tx_idle), .uart_tx(uart_tx),
    .uart_rx(w_uart_rx), .uart_int(uart_int)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_tx"},    uart_tx,  1'b1);
    check({tag, "_rdy"},   tx_ready, 1'b0);
    check({tag, "_rvld"},  rx_valid, 1'b0);
    check({tag, "_rdata"}, rx_data,  8'h00);
    check({tag, "_perr"},  rx_perr,  1'b0);
    check({tag, "_ferr"},  rx_ferr,  1'b0);
    check({tag, "_ovf"},   rx_ovf,   1'b0);
    check({tag, "_idle"},  tx_idle,  1'b1);
    check({tag, "_int"},   uart_int, 1'b0);
  endtask

  // Push one byte and compare every cycle of the serial frame against the expected bits.
  task automatic tx_frame(input logic [7:0] d, input logic pen, input logic podd,
                          input logic st2, input logic exp_par, input string tag);
    logic [11:0] bits;
    logic [15:0] cap;
    int nb;
    cfg_prty_en = pen; cfg_prty_odd = podd; cfg_stop2 = st2;
    bits = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
    nb = 9;
    if (pen) begin bits[nb] = exp_par; nb++; end
    bits[nb] = 1'b1; nb++;
    if (st2) begin bits[nb] = 1'b1; nb++; end
    tx_data = d; tx_valid = 1'b1;
    @(negedge uart_clk);
    tx_valid = 1'b0;
    check({tag, "_busy"}, tx_idle, 1'b0);
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < 16; c++) begin
        @(negedge uart_clk);
        cap[c] = uart_tx;
      end
      check($sformatf("%s_bit%0d", tag, b), cap, {16{bits[b]}});
    end
    check({tag, "_notidle"}, tx_idle, 1'b0);
    @(negedge uart_clk);
    check({tag, "_idle"}, tx_idle, 1'b1);
  endtask

  task automatic rx_send(input logic [7:0] d, input logic pen, input logic pb, input logic stopv);
    logic [10:0] f;
    int nb;
    f = '0;
    f[8:1] = d;
    nb = 9;
    if (pen) begin f[9] = pb; nb = 10; end
    f[nb] = stopv;
    nb++;
    for (int b = 0; b < nb; b++) begin
      r_rx_drv = f[b];
      repeat (16) @(negedge uart_clk);
    end
    r_rx_drv = 1'b1;
    repeat (8) @(negedge uart_clk);
  endtask

  task automatic pop_rx();
    rx_ready = 1'b1;
    @(negedge uart_clk);
    rx_ready = 1'b0;
  endtask

  task automatic loopback();
    logic [7:0] lb [3];
    lb[0] = 8'h3C; lb[1] = 8'hFF; lb[2] = 8'h00;
    loop = 1'b1;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          int n;
          n = 0;
          while (!tx_ready && n < 1000) begin @(negedge uart_clk); n++; end
          check("lb_txrdy", tx_ready, 1'b1);
          tx_data = lb[i]; tx_valid = 1'b1;
          @(negedge uart_clk);
          tx_valid = 1'b0;
        end
      end
      begin
        for (int j = 0; j < 3; j++) begin
          int m;
          m = 0;
          while (!rx_valid && m < 2000) begin @(negedge uart_clk); m++; end
          check($sformatf("lb_vld%0d", j), rx_valid, 1'b1);
          check($sformatf("lb_data%0d", j), rx_data, lb[j]);
          check($sformatf("lb_perr%0d", j), rx_perr, 1'b0);
          check($sformatf("lb_ferr%0d", j), rx_ferr, 1'b0);
          pop_rx();
        end
      end
    join
    repeat (40) @(negedge uart_clk);
    loop = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ovd [5];
    ovd[0] = 8'h11; ovd[1] = 8'h22; ovd[2] = 8'h33; ovd[3] = 8'h44; ovd[4] = 8'h55;
    sys_rstn = 1'b0; cfg_en = 1'b1; cfg_div = 16'd0; cfg_prty_en = 1'b0; cfg_prty_odd = 1'b0;
    cfg_stop2 = 1'b0; cfg_txie = 1'b0; cfg_rxie = 1'b0; err_clr = 1'b0; tx_valid = 1'b0;
    tx_data = 8'h00; rx_ready = 1'b0; loop = 1'b0; r_rx_drv = 1'b1;
    repeat (3) @(negedge uart_clk);
    chk_reset_vals("rst");
    sys_rstn = 1'b1;
    repeat (3) @(negedge uart_clk);
    check("rdy_after_rst", tx_ready, 1'b1);
    cfg_txie = 1'b1; #1;
    check("int_txidle", uart_int, 1'b1);
    cfg_txie = 1'b0; #1;
    check("int_off", uart_int, 1'b0);
    @(negedge uart_clk);

    tx_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, "tx8n1");
    tx_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, "txeven");
    tx_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, "txodd");
    cfg_prty_en = 1'b0; cfg_prty_odd = 1'b0; cfg_stop2 = 1'b0;

    cfg_en = 1'b0;
    @(negedge uart_clk);
    check("dis_rdy", tx_ready, 1'b0);
    check("dis_tx", uart_tx, 1'b1);
    cfg_en = 1'b1;
    repeat (4) @(negedge uart_clk);

    loopback();

    r_rx_drv = 1'b0;
    repeat (4) @(negedge uart_clk);
    r_rx_drv = 1'b1;
    repeat (40) @(negedge uart_clk);
    check("glitch_vld", rx_valid, 1'b0);

    cfg_rxie = 1'b1;
    rx_send(8'h5A, 1'b0, 1'b0, 1'b0);
    check("ferr_vld", rx_valid, 1'b1);
    check("ferr_data", rx_data, 8'h5A);
    check("ferr_flag", rx_ferr, 1'b1);
    check("ferr_perr", rx_perr, 1'b0);
    check("ferr_int", uart_int, 1'b1);
    pop_rx();
    check("ferr_int_off", uart_int, 1'b0);
    cfg_rxie = 1'b0;

    cfg_prty_en = 1'b1; cfg_prty_odd = 1'b0;
    rx_send(8'hA5, 1'b1, 1'b1, 1'b1);
    check("perr_data", rx_data, 8'hA5);
    check("perr_flag", rx_perr, 1'b1);
    check("perr_ferr", rx_ferr, 1'b0);
    pop_rx();
    cfg_prty_en = 1'b0;

    for (int i = 0; i < DEPTH; i++) rx_send(ovd[i], 1'b0, 1'b0, 1'b1);
    check("ovf_before", rx_ovf, 1'b0);
    check("int_before", uart_int, 1'b0);
    rx_send(ovd[DEPTH], 1'b0, 1'b0, 1'b1);
    check("ovf_set", rx_ovf, 1'b1);
    check("ovf_int", uart_int, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("ovf_data%0d", i), rx_data, ovd[i]);
      pop_rx();
    end
    check("ovf_lost", rx_valid, 1'b0);
    check("ovf_sticky", rx_ovf, 1'b1);
    err_clr = 1'b1;
    @(negedge uart_clk);
    err_clr = 1'b0;
    check("ovf_clr", rx_ovf, 1'b0);
    check("ovf_int_clr", uart_int, 1'b0);

    loop = 1'b1;
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge uart_clk);
    tx_valid = 1'b0;
    repeat (70) @(negedge uart_clk);
    check("mid_bit3", uart_tx, 1'b0);
    #2 sys_rstn = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge uart_clk);
    sys_rstn = 1'b1;
    repeat (300) @(negedge uart_clk);
    check("midrst_nopush", rx_valid, 1'b0);
    check("midrst_idle", tx_idle, 1'b1);
    check("midrst_tx", uart_tx, 1'b1);
    loop = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
